imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
- Pipelined, parametrised immediate generator for the single-cycle-to-pipelined ARMv8 subset datapath.
- Sits between instruction fetch/decode and the ALU/branch/address units.
- Accepts one 32-bit instruction per handshake and classifies its immediate format: B, CB, D, I or IW (MOVZ/MOVK).
- Emits the sign- or zero-extended immediate at DATA_W bits, plus a format tag and an illegal flag.
- Keeps a saturating count of unrecognised instructions.

Parameters:
- DATA_W, 64, output immediate width. Legal values: 32 or 64. Results are truncated to DATA_W.
- STAGES, 2, pipeline depth (legal values 1 or 2). Stage 1 registers the decoded format and raw field; stage 2 registers the extended result. When STAGES=1, both are done in one register stage.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instr is valid
- in_ready  out  1  block can accept instr this cycle
- instr  in  32  instruction word
- out_valid  out  1  imm/fmt/illegal are valid
- out_ready  in  1  consumer accepts output this cycle
- imm  out  DATA_W  extended immediate
- fmt  out  3  format tag: 0 none, 1 B, 2 CB, 3 D, 4 I, 5 IW
- illegal  out  1  instruction matched no format
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset state: all stage valids=0, out_valid=0, imm=0, fmt=0, illegal=0, illegal_cnt=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight entries are discarded, with no output. This takes priority over any handshake in the same cycle.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage advance: a stage loads when it is empty, or when its contents move onward in the same cycle.
- in_ready: in_ready = !s1_valid || s1_advances. This is combinational from out_ready through the stages; no skid buffer.
- Latency: STAGES cycles from input transfer to out_valid, with no bubbles when out_ready=1. Full throughput is 1 per cycle.
- Stall: outputs are held stable while out_valid && !out_ready. Order is always preserved.
- Decode (first matching rule wins):
  - B: instr[31:26]=000101. Sign-extend imm26 = instr[25:0].
  - CB: instr[31:24]=10110100 (CBZ) or 10110101 (CBNZ). Sign-extend instr[23:5].
  - D: instr[31:21]=11111000000 (STUR) or 11111000010 (LDUR). Sign-extend instr[20:12].
  - I: instr[31:22]=1001000100 (ADDI) or 1101000100 (SUBI). Zero-extend instr[21:10].
  - IW: instr[31:23]=110100101 (MOVZ) or 111100101 (MOVK). Output zero-extend(instr[20:5]) << (16*instr[22:21]).
  - If 16*hw >= DATA_W: imm=0, illegal=1, fmt=5.
  - Otherwise: fmt=0, imm=0, illegal=1.
- illegal_cnt:
  - Increments by 1 on each input transfer whose instruction decodes illegal.
  - Updates at acceptance, not at output.
  - Saturates at all-ones and does not wrap.
  - Clears only on reset.

Optional Feature:
- Macro: IMM_BRANCH_SCALE_EN.
- Defined: B and CB immediates are left-shifted by 2 after sign extension (word offset to byte offset). Bits beyond DATA_W are dropped.
- Undefined: branch immediates are output as raw word offsets.
- D, I and IW formats are unaffected in both cases.

Test Plan:
- B format, DATA_W=64: instr=0x17FFFFFF, out_ready=1 -> after STAGES cycles, imm=0xFFFFFFFFFFFFFFFF, fmt=1, illegal=0. With IMM_BRANCH_SCALE_EN: imm=0xFFFFFFFFFFFFFFFC.
- CB and D back-to-back: CBNZ 0xB5000040 then LDUR 0xF85F8000, back-to-back -> consecutive outputs:
  - imm=0x2, fmt=2.
  - then imm=0xFFFFFFFFFFFFFFF8, fmt=3.
- IW shift and width limit: MOVK 0xF2E24680 -> imm=0x1234000000000000, fmt=5. With DATA_W=32, the same instruction -> imm=0, illegal=1, illegal_cnt=1.
- Backpressure, STAGES=2: out_ready=0, then send ADDI 0x91000C00, 0x91001000, 0x91001400 -> in_ready=0 after 2 accepts. Release out_ready -> outputs are imm=3, 4, 5 in order; the third instruction is then accepted.
- Illegal counter saturation, CNT_W=2: five 0x00000000 instructions -> illegal_cnt goes 1, 2, 3, 3, 3, and every output has fmt=0, imm=0.
- Reset mid-operation: assert reset for 1 cycle with two entries in flight -> next cycle out_valid=0, imm=0, illegal_cnt=0, in_ready=1, and no stale output ever appears.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined ARMv8-subset immediate generator (B/CB/D/I/IW formats).
// Optional IMM_BRANCH_SCALE_EN: B/CB immediates are emitted as byte offsets (<<2).
module imm_extend_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        fmt,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  typedef enum logic [2:0] {
    F_NONE = 3'd0,
    F_B    = 3'd1,
    F_CB   = 3'd2,
    F_D    = 3'd3,
    F_I    = 3'd4,
    F_IW   = 3'd5
  } fmt_e;

  fmt_e dec_fmt;
  logic dec_ill;

  always_comb begin
    dec_fmt = F_NONE;
    dec_ill = 1'b0;
    if (instr[31:26] == 6'b000101) begin
      dec_fmt = F_B;
    end else if (instr[31:25] == 7'b1011010) begin
      dec_fmt = F_CB;
    end else if (instr[31:21] == 11'b11111000000 || instr[31:21] == 11'b11111000010) begin
      dec_fmt = F_D;
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      dec_fmt = F_I;
    end else if (instr[31:23] == 9'b110100101 || instr[31:23] == 9'b111100101) begin
      dec_fmt = F_IW;
      // A halfword shift that lands entirely above the output width is unrepresentable
      if (int'({instr[22:21], 4'b0000}) >= int'(DATA_W)) dec_ill = 1'b1;
    end else begin
      dec_ill = 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] extend(input fmt_e f, input logic [25:0] raw,
                                               input logic ill);
    logic [63:0] t;
    t = '0;
    if (!ill) begin
      case (f)
        F_B:     t = {{38{raw[25]}}, raw};
        F_CB:    t = {{45{raw[23]}}, raw[23:5]};
        F_D:     t = {{55{raw[20]}}, raw[20:12]};
        F_I:     t = {52'd0, raw[21:10]};
        F_IW:    t = {48'd0, raw[20:5]} << {raw[22:21], 4'b0000};
        default: t = '0;
      endcase
    end
`ifdef IMM_BRANCH_SCALE_EN
    if (f == F_B || f == F_CB) t = t << 2;
`else
`endif
    return t[DATA_W-1:0];
  endfunction

  logic              ov_q;
  logic [DATA_W-1:0] imm_q;
  fmt_e              fmt_q;
  logic              ill_q;
  logic [CNT_W-1:0]  cnt_q;

  if (STAGES == 1) begin : g_one
    logic ld;
    assign ld       = !ov_q || out_ready;
    assign in_ready = ld;

    always_ff @(posedge clk) begin
      if (reset) begin
        ov_q  <= 1'b0;
        imm_q <= '0;
        fmt_q <= F_NONE;
        ill_q <= 1'b0;
      end else if (ld) begin
        ov_q <= in_valid;
        if (in_valid) begin
          imm_q <= extend(dec_fmt, instr[25:0], dec_ill);
          fmt_q <= dec_fmt;
          ill_q <= dec_ill;
        end
      end
    end
  end else begin : g_two
    logic        s1_valid;
    fmt_e        s1_fmt;
    logic [25:0] s1_raw;
    logic        s1_ill;
    logic        s2_ld;

    // Stage 2 can take new data when empty or draining; stage 1 advances exactly then
    assign s2_ld    = !ov_q || out_ready;
    assign in_ready = !s1_valid || s2_ld;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_fmt   <= F_NONE;
        s1_raw   <= '0;
        s1_ill   <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_fmt <= dec_fmt;
          s1_raw <= instr[25:0];
          s1_ill <= dec_ill;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ov_q  <= 1'b0;
        imm_q <= '0;
        fmt_q <= F_NONE;
        ill_q <= 1'b0;
      end else if (s2_ld) begin
        ov_q <= s1_valid;
        if (s1_valid) begin
          imm_q <= extend(s1_fmt, s1_raw, s1_ill);
          fmt_q <= s1_fmt;
          ill_q <= s1_ill;
        end
      end
    end
  end

  // Counted at acceptance so the total is independent of downstream backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (in_valid && in_ready && dec_ill && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = ov_q;
  assign imm         = imm_q;
  assign fmt         = fmt_q;
  assign illegal     = ill_q;
  assign illegal_cnt = cnt_q;

endmodule
